// File: rtl/tensor_core_result_reader.sv
// tensor_core_result_reader
//   Reader end of the tensor-core result interface. Detects a rising edge
//   on the MMA core's done level, snapshots the result matrix and streams
//   its elements out one per handshake on a valid/ready channel, either
//   row-major or column-major.
//
// Ports
//   clock_in                 : clock, all state on the rising edge
//   reset_in_n               : asynchronous active-low reset
//   is_done_with_calculation : done level from the MMA core
//   tensor_core_output       : result matrix, element (i,j) at
//                              [((D-1-i)*D+(D-1-j))*W +: W]
//   column_major             : order select, sampled at capture
//   clear_overrun            : synchronous clear of the overrun flag
//   out_data/out_valid/out_ready/out_last/out_index : element stream
//   busy                     : high while streaming
//   overrun                  : sticky, a result was dropped mid-stream
module tensor_core_result_reader #(
    parameter int unsigned MATRIX_DIM    = 4,
    parameter int unsigned ELEMENT_WIDTH = 8
) (
    input  logic                                            clock_in,
    input  logic                                            reset_in_n,
    input  logic                                            is_done_with_calculation,
    input  logic [MATRIX_DIM*MATRIX_DIM*ELEMENT_WIDTH-1:0]  tensor_core_output,
    input  logic                                            column_major,
    input  logic                                            clear_overrun,
    output logic [ELEMENT_WIDTH-1:0]                        out_data,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic                                            out_last,
    output logic [$clog2(MATRIX_DIM*MATRIX_DIM)-1:0]        out_index,
    output logic                                            busy,
    output logic                                            overrun
);

    localparam int unsigned NUM_ELEM = MATRIX_DIM * MATRIX_DIM;
    localparam int unsigned BUS_W    = NUM_ELEM * ELEMENT_WIDTH;
    localparam int unsigned IDX_W    = $clog2(NUM_ELEM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t             state_q,     state_d;
    logic [BUS_W-1:0]   snapshot_q,  snapshot_d;
    logic               order_q,     order_d;
    logic [IDX_W-1:0]   counter_q,   counter_d;
    logic               done_prev_q, done_prev_d;
    logic               overrun_q,   overrun_d;

    logic               done_rise;
    logic               handshake;
    logic               final_hs;

    int unsigned        elem_k;
    int unsigned        elem_row;
    int unsigned        elem_col;
    int unsigned        elem_flat;
    logic [ELEMENT_WIDTH-1:0] elem_sel;

    assign done_rise = is_done_with_calculation && !done_prev_q;
    assign handshake = (state_q == STREAM) && out_ready;
    assign final_hs  = handshake && (counter_q == LAST_IDX);

    // Element k of the stream: (k/D, k%D) row-major, (k%D, k/D) column-major.
    // The bus stores element (0,0) in the most significant slot.
    always_comb begin
        elem_k    = 32'(counter_q);
        elem_row  = order_q ? (elem_k % MATRIX_DIM) : (elem_k / MATRIX_DIM);
        elem_col  = order_q ? (elem_k / MATRIX_DIM) : (elem_k % MATRIX_DIM);
        elem_flat = elem_row * MATRIX_DIM + elem_col;
        elem_sel  = snapshot_q[(NUM_ELEM - 1 - elem_flat) * ELEMENT_WIDTH +: ELEMENT_WIDTH];
    end

    always_comb begin
        state_d     = state_q;
        snapshot_d  = snapshot_q;
        order_d     = order_q;
        counter_d   = counter_q;
        done_prev_d = is_done_with_calculation;
        overrun_d   = overrun_q;

        if (clear_overrun) begin
            overrun_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (done_rise) begin
                    snapshot_d = tensor_core_output;
                    order_d    = column_major;
                    counter_d  = '0;
                    state_d    = STREAM;
                end
            end
            STREAM: begin
                if (handshake) begin
                    counter_d = counter_q + IDX_W'(1);
                end
                if (final_hs) begin
                    // A result arriving exactly on the last beat is taken
                    // back-to-back instead of being dropped.
                    if (done_rise) begin
                        snapshot_d = tensor_core_output;
                        order_d    = column_major;
                        counter_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (done_rise) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_in_n) begin
        if (!reset_in_n) begin
            state_q     <= IDLE;
            snapshot_q  <= '0;
            order_q     <= 1'b0;
            counter_q   <= '0;
            done_prev_q <= 1'b1;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            snapshot_q  <= snapshot_d;
            order_q     <= order_d;
            counter_q   <= counter_d;
            done_prev_q <= done_prev_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = (state_q == STREAM);
    assign busy      = (state_q == STREAM);
    assign out_last  = (state_q == STREAM) && (counter_q == LAST_IDX);
    assign out_index = counter_q;
    assign out_data  = out_valid ? elem_sel : '0;
    assign overrun   = overrun_q;

endmodule
